// File: rtl/ram_arb_pkg.sv
// Shared types for the two-port RAM arbiter.
// Requester ids, response tags and default widths.
package ram_arb_pkg;

  typedef enum logic {
    ID_A = 1'b0,
    ID_B = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 6;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with a last-served register.
// Grants are combinational; the pointer moves only on a grant.
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic a_req,
  input  logic b_req,
  output logic a_gnt,
  output logic b_gnt
);

  req_id_t last_grant;

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!reset) begin
      unique case ({a_req, b_req})
        2'b10:   a_gnt = 1'b1;
        2'b01:   b_gnt = 1'b1;
        2'b11: begin
          a_gnt = (last_grant == ID_B);
          b_gnt = (last_grant == ID_A);
        end
        default: ;
      endcase
    end
  end

  // Reset marks B as last served so A wins the first contention.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= ID_B;
    end else if (a_gnt) begin
      last_grant <= ID_A;
    end else if (b_gnt) begin
      last_grant <= ID_B;
    end
  end

endmodule

// File: rtl/ram_arbiter_2p.sv
// Shares one single-port synchronous RAM between requesters A and B.
// Read results are routed back through a tag pipeline of depth RD_LAT.
module ram_arbiter_2p
  import ram_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  logic              a_gnt;
  logic              b_gnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  tag_t              push;
  tag_t              tail;
  tag_t [RD_LAT-1:0] pipe;

  rr_arbiter2 u_arb (
    .clock (clock),
    .reset (reset),
    .a_req (a_valid),
    .b_req (b_valid),
    .a_gnt (a_gnt),
    .b_gnt (b_gnt)
  );

  assign a_ready = a_gnt;
  assign b_ready = b_gnt;
  assign ram_we  = (a_gnt & a_we) | (b_gnt & b_we);

  always_comb begin
    ram_addr = addr_q;
    ram_data = data_q;
    unique case (1'b1)
      a_gnt: begin
        ram_addr = a_addr;
        ram_data = a_wdata;
      end
      b_gnt: begin
        ram_addr = b_addr;
        ram_data = b_wdata;
      end
      default: ;
    endcase
  end

  // Idle cycles replay the last granted address and data.
  always_ff @(posedge clock) begin
    if (a_gnt | b_gnt) begin
      addr_q <= ram_addr;
      data_q <= ram_data;
    end
  end

  always_comb begin
    push.valid = (a_gnt & ~a_we) | (b_gnt & ~b_we);
    push.id    = b_gnt ? ID_B : ID_A;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pipe <= '0;
    end else begin
      pipe[0] <= push;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign tail     = pipe[RD_LAT-1];
  assign a_rvalid = ~reset & tail.valid & (tail.id == ID_A);
  assign b_rvalid = ~reset & tail.valid & (tail.id == ID_B);
  assign a_rdata  = ram_q;
  assign b_rdata  = ram_q;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Bench for ram_arbiter_2p at RD_LAT 1 and 2, sharing one stimulus stream.
// Directed table plus random traffic against a transaction-level model.
module tb_ram_arbiter_2p;

  typedef struct {
    bit         rst;
    bit         av;
    bit         awe;
    logic [5:0] aa;
    logic [7:0] ad;
    bit         bv;
    bit         bwe;
    logic [5:0] ba;
    logic [7:0] bd;
    bit         ear;
    bit         ebr;
    bit         eav;
    bit         ebv;
    logic [7:0] erd;
  } vec_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       a_valid, a_we, b_valid, b_we;
  logic [5:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;

  logic       ar1, br1, arv1, brv1, rwe1;
  logic [7:0] ard1, brd1, rdat1, q1;
  logic [5:0] radr1;
  logic       ar2, br2, arv2, brv2, rwe2;
  logic [7:0] ard2, brd2, rdat2, q2, q2a;
  logic [5:0] radr2;

  ram_arbiter_2p #(.DATA_W(8), .ADDR_W(6), .RD_LAT(1)) u1 (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(ar1), .a_we(a_we),
    .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rvalid(arv1), .a_rdata(ard1),
    .b_valid(b_valid), .b_ready(br1), .b_we(b_we),
    .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rvalid(brv1), .b_rdata(brd1),
    .ram_addr(radr1), .ram_data(rdat1), .ram_we(rwe1),
    .ram_q(q1)
  );

  ram_arbiter_2p #(.DATA_W(8), .ADDR_W(6), .RD_LAT(2)) u2 (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(ar2), .a_we(a_we),
    .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rvalid(arv2), .a_rdata(ard2),
    .b_valid(b_valid), .b_ready(br2), .b_we(b_we),
    .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rvalid(brv2), .b_rdata(brd2),
    .ram_addr(radr2), .ram_data(rdat2), .ram_we(rwe2),
    .ram_q(q2)
  );

  // RAM instances behind each arbiter
  logic [7:0] mem1 [64];
  logic [7:0] mem2 [64];

  always @(posedge clock) begin
    if (rwe1) mem1[radr1] <= rdat1;
    q1 <= mem1[radr1];
    if (rwe2) mem2[radr2] <= rdat2;
    q2a <= mem2[radr2];
    q2  <= q2a;
  end

  // Reference model state
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  bit         a_turn;
  logic [7:0] ref_mem [64];
  bit         known [64];
  bit         have_last;
  logic [5:0] last_addr;
  logic [7:0] last_data;
  bit         hr [2048];
  bit         hv [2048];
  bit         hid [2048];
  bit         hk [2048];
  logic [7:0] hd [2048];
  bit         last_ga, last_gb;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic resp_chk(input int lat, input string s,
                          input logic arv, input logic brv,
                          input logic [7:0] ard, input logic [7:0] brd);
    int idx;
    bit v;
    bit id;
    idx = cyc - lat;
    v = 1'b0;
    id = 1'b0;
    if (idx >= 0) begin
      v = hv[idx];
      id = hid[idx];
      for (int j = idx + 1; j <= cyc; j++) if (hr[j]) v = 1'b0;
    end
    chk({s, " a_rvalid"}, arv, v && !id);
    chk({s, " b_rvalid"}, brv, v && id);
    if (v && hk[idx]) begin
      if (!id) chk({s, " a_rdata"}, ard, hd[idx]);
      else     chk({s, " b_rdata"}, brd, hd[idx]);
    end
  endtask

  task automatic cycle(input bit use_row, input vec_t r);
    bit ga, gb;
    logic [5:0] ea;
    logic [7:0] ed;
    @(negedge clock);
    hr[cyc] = reset;
    ga = !reset && a_valid && (!b_valid || a_turn);
    gb = !reset && b_valid && (!a_valid || !a_turn);
    chk("l1 a_ready", ar1, ga);
    chk("l1 b_ready", br1, gb);
    chk("l2 a_ready", ar2, ga);
    chk("l2 b_ready", br2, gb);
    chk("l1 ram_we", rwe1, (ga && a_we) || (gb && b_we));
    chk("l2 ram_we", rwe2, (ga && a_we) || (gb && b_we));
    ea = ga ? a_addr : b_addr;
    ed = ga ? a_wdata : b_wdata;
    if (!ga && !gb) begin
      ea = last_addr;
      ed = last_data;
    end
    if (ga || gb || have_last) begin
      chk("l1 ram_addr", radr1, ea);
      chk("l1 ram_data", rdat1, ed);
      chk("l2 ram_addr", radr2, ea);
    end
    resp_chk(1, "l1", arv1, brv1, ard1, brd1);
    resp_chk(2, "l2", arv2, brv2, ard2, brd2);
    if (use_row) begin
      chk("row a_ready", ar1, r.ear);
      chk("row b_ready", br1, r.ebr);
      chk("row a_rvalid", arv1, r.eav);
      chk("row b_rvalid", brv1, r.ebv);
      if (r.eav) chk("row a_rdata", ard1, r.erd);
      if (r.ebv) chk("row b_rdata", brd1, r.erd);
    end
    hv[cyc]  = (ga && !a_we) || (gb && !b_we);
    hid[cyc] = gb;
    hd[cyc]  = ref_mem[ea];
    hk[cyc]  = known[ea];
    @(posedge clock);
    if (reset) begin
      a_turn = 1'b1;
      have_last = 1'b0;
    end else if (ga || gb) begin
      a_turn = gb;
      have_last = 1'b1;
      last_addr = ea;
      last_data = ed;
      if ((ga && a_we) || (gb && b_we)) begin
        ref_mem[ea] = ed;
        known[ea] = 1'b1;
      end
    end
    last_ga = ga;
    last_gb = gb;
    cyc++;
    #1;
  endtask

  function automatic vec_t mk(
    bit rst, bit av, bit awe, int aa, int ad,
    bit bv, bit bwe, int ba, int bd,
    bit ear, bit ebr, bit eav, bit ebv, int erd);
    vec_t v;
    v.rst = rst; v.av = av; v.awe = awe;
    v.aa = 6'(aa); v.ad = 8'(ad);
    v.bv = bv; v.bwe = bwe;
    v.ba = 6'(ba); v.bd = 8'(bd);
    v.ear = ear; v.ebr = ebr; v.eav = eav; v.ebv = ebv;
    v.erd = 8'(erd);
    return v;
  endfunction

  vec_t tbl [28];
  vec_t none;

  bit         pa, pawe, pb, pbwe;
  logic [5:0] paa, pba;
  logic [7:0] pad, pbd;

  initial begin
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = 8'h00;
      known[i] = 1'b0;
    end
    a_turn = 1'b1;
    have_last = 1'b0;
    last_addr = '0;
    last_data = '0;
    none = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0);

    tbl[0]  = mk(1, 1,1,0,8'h01, 1,1,2,8'h03, 0,0,0,0,0);
    tbl[1]  = mk(1, 1,1,0,8'h01, 1,1,2,8'h03, 0,0,0,0,0);
    tbl[2]  = mk(0, 1,1,0,8'h01, 1,1,2,8'h03, 1,0,0,0,0);
    tbl[3]  = mk(0, 0,0,0,0,     1,1,2,8'h03, 0,1,0,0,0);
    tbl[4]  = mk(0, 1,0,0,0,     0,0,0,0,     1,0,0,0,0);
    tbl[5]  = mk(0, 0,0,0,0,     0,0,0,0,     0,0,1,0,8'h01);
    tbl[6]  = mk(0, 0,0,0,0,     1,0,2,0,     0,1,0,0,0);
    tbl[7]  = mk(0, 1,1,1,8'h02, 1,1,2,8'h03, 1,0,0,1,8'h03);
    tbl[8]  = mk(0, 1,0,2,0,     1,1,2,8'h03, 0,1,0,0,0);
    tbl[9]  = mk(0, 1,0,2,0,     1,0,1,0,     1,0,0,0,0);
    tbl[10] = mk(0, 0,0,0,0,     1,0,1,0,     0,1,1,0,8'h03);
    tbl[11] = mk(0, 0,0,0,0,     0,0,0,0,     0,0,0,1,8'h02);
    tbl[12] = mk(0, 1,1,5,8'hAA, 1,1,5,8'hBB, 1,0,0,0,0);
    tbl[13] = mk(0, 1,0,5,0,     1,1,5,8'hBB, 0,1,0,0,0);
    tbl[14] = mk(0, 1,0,5,0,     0,0,0,0,     1,0,0,0,0);
    tbl[15] = mk(0, 0,0,0,0,     0,0,0,0,     0,0,1,0,8'hBB);
    tbl[16] = mk(0, 1,1,1,8'h04, 0,0,0,0,     1,0,0,0,0);
    tbl[17] = mk(0, 1,0,1,0,     0,0,0,0,     1,0,0,0,0);
    tbl[18] = mk(0, 0,0,0,0,     0,0,0,0,     0,0,1,0,8'h04);
    tbl[19] = mk(0, 1,1,3,8'h5A, 0,0,0,0,     1,0,0,0,0);
    tbl[20] = mk(0, 1,0,3,0,     0,0,0,0,     1,0,0,0,0);
    tbl[21] = mk(1, 0,0,0,0,     0,0,0,0,     0,0,0,0,0);
    tbl[22] = mk(0, 0,0,0,0,     0,0,0,0,     0,0,0,0,0);
    tbl[23] = mk(0, 1,0,3,0,     1,0,0,0,     1,0,0,0,0);
    tbl[24] = mk(0, 0,0,0,0,     1,0,0,0,     0,1,1,0,8'h5A);
    tbl[25] = mk(0, 0,0,0,0,     0,0,0,0,     0,0,0,1,8'h01);
    tbl[26] = mk(0, 0,0,0,0,     0,0,0,0,     0,0,0,0,0);
    tbl[27] = mk(0, 0,0,0,0,     0,0,0,0,     0,0,0,0,0);

    for (int i = 0; i < 28; i++) begin
      reset   = tbl[i].rst;
      a_valid = tbl[i].av;
      a_we    = tbl[i].awe;
      a_addr  = tbl[i].aa;
      a_wdata = tbl[i].ad;
      b_valid = tbl[i].bv;
      b_we    = tbl[i].bwe;
      b_addr  = tbl[i].ba;
      b_wdata = tbl[i].bd;
      cycle(1'b1, tbl[i]);
    end

    // Saturated contention first, then mixed random traffic
    pa = 1'b0;
    pb = 1'b0;
    pawe = 1'b0; pbwe = 1'b0;
    paa = '0; pba = '0; pad = '0; pbd = '0;
    for (int n = 0; n < 420; n++) begin
      int p;
      p = (n < 20) ? 100 : 65;
      if (!pa && $urandom_range(0, 99) < p) begin
        pa = 1'b1;
        pawe = 1'($urandom_range(0, 1));
        paa = 6'($urandom_range(0, 7));
        pad = 8'($urandom);
      end
      if (!pb && $urandom_range(0, 99) < p) begin
        pb = 1'b1;
        pbwe = 1'($urandom_range(0, 1));
        pba = 6'($urandom_range(0, 7));
        pbd = 8'($urandom);
      end
      reset   = (n >= 20) && ($urandom_range(0, 99) < 3);
      a_valid = pa; a_we = pawe; a_addr = paa; a_wdata = pad;
      b_valid = pb; b_we = pbwe; b_addr = pba; b_wdata = pbd;
      cycle(1'b0, none);
      if (last_ga) pa = 1'b0;
      if (last_gb) pb = 1'b0;
    end

    reset = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    for (int n = 0; n < 4; n++) cycle(1'b0, none);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_arbiter_2p.md
Name: ram_arbiter_2p

Overview:
- Shares one single-port synchronous RAM (DATA_W data, ADDR_W address, one write-enable, registered read output) between two requesters, A and B.
- Each requester has a valid/ready request channel and a read-response channel.
- When both requesters contend, a round-robin arbiter grants one access per clock.
- A tag pipeline matching the RAM read latency returns each read result to the requester that issued it.
- Sits between the RAM instance and the two client blocks; the RAM itself is unchanged.

Parameters:
- DATA_W, 8, RAM data width.
- ADDR_W, 6, RAM address width (64 words).
- RD_LAT, 1, cycles from the RAM sampling an address to valid ram_q; legal range 1..4.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- a_valid  in  1  requester A has a request.
- a_ready  out  1  A's request is accepted this cycle.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  ADDR_W  A's address.
- a_wdata  in  DATA_W  A's write data.
- a_rvalid  out  1  A's read data is valid this cycle.
- a_rdata  out  DATA_W  A's read data.
- b_valid, b_ready, b_we, b_addr, b_wdata, b_rvalid, b_rdata: same as A, for requester B.
- ram_addr  out  ADDR_W  to RAM addr.
- ram_data  out  DATA_W  to RAM data.
- ram_we  out  1  to RAM we.
- ram_q  in  DATA_W  from RAM q.

Behaviour:
- The clock port is named clock and the reset port is named reset. There is one clock domain. Reset is synchronous and active-high; it is sampled only on the rising edge of clock.
- Reset values:
  - a_ready = b_ready = 0 and ram_we = 0 while reset is high (combinational gating).
  - The round-robin pointer resets to A (A wins the first contention).
  - The tag pipeline resets to all-empty, so a_rvalid = b_rvalid = 0.
- Arbitration is combinational within the cycle. The pointer is a register named last_grant.
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the requester not served by the most recent grant.
  - Neither valid: no grant and no RAM access; ram_we = 0.
  - last_grant updates only on a cycle with a grant.
- Ready rules:
  - a_ready = grant_A and b_ready = grant_B. At most one is high per cycle.
  - Ready never depends on the requester's own ready.
  - A transfer happens when valid & ready are both high at the rising edge.
  - A requester must hold valid, we, addr and wdata stable until accepted.
- RAM drive is a combinational mux of the granted requester: ram_addr and ram_data come from the granted requester, ram_we = granted & we.
  - With no grant, ram_addr and ram_data hold their last granted values, which keeps RAM inputs quiet. ram_we = 0.
- Writes are committed by the RAM at the acceptance edge. There is no response for writes.
- Reads use a tag pipeline of RD_LAT stages; each entry is {valid, id}.
  - An accepted read pushes {1, id}; any other cycle pushes {0, x}.
  - The stage-RD_LAT output drives a_rvalid (valid & id = A) and b_rvalid (valid & id = B).
  - a_rdata = b_rdata = ram_q (pass-through). Only the matching rvalid qualifies the data.
  - Read response latency is exactly RD_LAT cycles after the acceptance edge, independent of contention.
  - Responses are never back-pressured; clients must always sink them.
- Ordering and hazards:
  - A read accepted on the cycle after a write to the same address returns the new data. The RAM has write-then-read ordering across cycles.
  - Both requesters writing the same address: whichever is accepted last wins.
  - A write and a read granted on consecutive cycles follow grant order.
- Throughput and fairness:
  - 1 access per cycle total.
  - Under continuous contention the grants alternate A, B, A, B; each requester is served at least every 2 cycles.
- Reset mid-operation:
  - The pipeline flushes. In-flight reads are dropped and produce no rvalid.
  - Requests pending during reset are not accepted.
  - After reset deasserts, arbitration restarts with A preferred.

Decomposition:
- Package ram_arb_pkg holds:
  - typedef req_id_t (1 bit: ID_A = 0, ID_B = 1);
  - a struct tag_t {valid, id};
  - default constants DATA_W_DEF = 8, ADDR_W_DEF = 6.
- One sub-module, rr_arbiter2: 2-way round-robin grant logic with the last_grant register.
- The top level holds the mux and the tag pipeline.

Test Plan:
- Reset priority: hold reset 2 cycles, then release.
  - Required: a_ready = b_ready = 0, ram_we = 0 and both rvalid = 0 during reset.
  - Required: a_valid and b_valid both asserted on the first post-reset cycle → A granted first.
- Solo write/read: A writes 8'h01 to addr 0, then reads addr 0.
  - Required: a_ready = 1 each cycle; a_rvalid = 1 with a_rdata = 8'h01 exactly RD_LAT cycles after the read is accepted; b_rvalid stays 0.
- Contention: A writes 8'h02 to addr 1 while B simultaneously writes 8'h03 to addr 2. Both then read the other's address.
  - Required: grant order A, B, A, B.
  - Required: a_rdata = 8'h03 and b_rdata = 8'h02, each with its own rvalid.
- Same-address race: A and B both write addr 5, A with 8'hAA and B with 8'hBB, with A granted first. Then A reads addr 5.
  - Required: the read returns 8'hBB.
- Back-to-back dependency: A writes 8'h04 to addr 1, and on the next cycle A reads addr 1.
  - Required: the read returns 8'h04 with no stall.
- Reset mid-read: A's read of addr 3 is accepted, and reset asserts on the next cycle.
  - Required: a_rvalid never asserts for that read.
  - Required: after reset, a normal read of addr 3 returns correct data.
  - Repeat the run with RD_LAT = 2 and check that latency.
